wm_block_ctrl: RTL

- Sequencer for the visible-watermark pixel equation datapath.
- Per image block k, it streams the primary block once to compute the block mean G_mu_k and latches the coefficient-mode decision.
- It then streams the primary and watermark blocks again, in lockstep, through the combinational equation datapath and issues write strobes/addresses for the watermarked output.
- Sits between the block pixel memories (primary, watermark, output) and the equation datapath; drives its G_mu_k input.

---
 rtl/wm_block_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wm_block_ctrl.sv
// wm_block_ctrl: block sequencer for the visible-watermark pixel equation.
// Each block is read once to form its mean G_mu_k and the coefficient-mode
// decision. It is then read again, primary and watermark in lockstep, while
// write strobes for the watermarked output trail the reads by one cycle.
module wm_block_ctrl #(
    parameter int Data_Depth = 8,
    parameter int Block_Log2 = 6,
    parameter int Addr_Width = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [Addr_Width-Block_Log2-1:0] num_blocks,
    input  logic [Data_Depth-1:0]            B_thr,
    input  logic [Data_Depth-1:0]            P_rd_data,
    output logic                             rd_en,
    output logic [Addr_Width-1:0]            rd_addr,
    output logic [Data_Depth-1:0]            G_mu_k,
    output logic                             mode_max,
    output logic                             wr_en,
    output logic [Addr_Width-1:0]            wr_addr,
    output logic                             busy,
    output logic                             done
);

    localparam int BW   = Addr_Width - Block_Log2;
    // A sum of 2**Block_Log2 pixels needs Block_Log2 extra bits, so it never wraps.
    localparam int AccW = Data_Depth + Block_Log2;
    localparam logic [Block_Log2-1:0] IdxLast = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEAN,
        S_MEAN_FLUSH,
        S_CALC,
        S_PROC,
        S_PROC_FLUSH,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic [Block_Log2-1:0] idx_q, idx_d;
    logic [BW-1:0]         count_q, count_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic                  rd_en_q, rd_en_d;
    logic                  mean_vld_q, mean_vld_d;
    logic                  wr_en_q, wr_en_d;
    logic [Addr_Width-1:0] wr_addr_q, wr_addr_d;
    logic [Data_Depth-1:0] g_mu_q, g_mu_d;
    logic                  mode_max_q, mode_max_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [Data_Depth-1:0] mean;

    // Floor of the block mean; the shifted sum always fits in Data_Depth bits.
    assign mean = Data_Depth'(acc_q >> Block_Log2);

    // Next-state, counters, accumulator and registered-output computation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        blk_d      = blk_q;
        idx_d      = idx_q;
        count_d    = count_q;
        acc_d      = acc_q;
        g_mu_d     = g_mu_q;
        mode_max_d = mode_max_q;

        // Read data for a MEAN-phase read arrives one cycle after its strobe.
        mean_vld_d = rd_en_q && (state_q == S_MEAN);
        if (mean_vld_q) begin
            acc_d = acc_q + AccW'(P_rd_data);
        end

        // Writes trail PROC-phase reads by the one-cycle memory latency.
        wr_en_d   = rd_en_q && (state_q == S_PROC);
        wr_addr_d = wr_en_d ? {blk_q, idx_q} : wr_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_blocks != '0) begin
                        count_d = num_blocks;
                        blk_d   = '0;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = S_MEAN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MEAN: begin
                idx_d = idx_q + Block_Log2'(1);
                if (idx_q == IdxLast) begin
                    state_d = S_MEAN_FLUSH;
                end
            end
            S_MEAN_FLUSH: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                g_mu_d     = mean;
                mode_max_d = (mean >= B_thr);
                idx_d      = '0;
                state_d    = S_PROC;
            end
            S_PROC: begin
                idx_d = idx_q + Block_Log2'(1);
                if (idx_q == IdxLast) begin
                    state_d = S_PROC_FLUSH;
                end
            end
            S_PROC_FLUSH: begin
                if (blk_q == count_q - BW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    blk_d   = blk_q + BW'(1);
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_MEAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they register cleanly.
        rd_en_d = (state_d == S_MEAN) || (state_d == S_PROC);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers; an asynchronous reset aborts any run at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            rd_en_q    <= 1'b0;
            mean_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            g_mu_q     <= '0;
            mode_max_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            rd_en_q    <= rd_en_d;
            mean_vld_q <= mean_vld_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            g_mu_q     <= g_mu_d;
            mode_max_q <= mode_max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = {blk_q, idx_q};
    assign G_mu_k   = g_mu_q;
    assign mode_max = mode_max_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
